iua_rst_ctrl: RTL and testbench
===============================

# iua_rst_ctrl

Reset sequencer for the analyzer's clock/reset subsystem. Sits downstream of the PLL and release logic, in the system clock domain. Watches the PLL lock, then releases N downstream reset domains one at a time with a fixed spacing. Also serves software-requested per-domain soft resets over a 4-phase req/ack handshake, and forces every domain back into reset on lock loss.

## Interface
Parameters:
- N_DOM, 4: number of downstream reset domains (1..8).
- LOCK_FILT, 8: consecutive synchronized lock-high cycles required before sequencing starts (≥1).
- REL_DELAY, 16: cycles between successive domain releases (≥1).
- SOFT_LEN, 8: cycles a soft reset is held asserted (≥1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  raw PLL lock; asynchronous to clk.
- sw_rst_req  in  N_DOM  level soft-reset request mask; bit i targets domain i.
- sw_rst_ack  out  1  level acknowledge of a completed soft reset.
- dom_rst  out  N_DOM  active-high reset per domain.
- all_ready  out  1  high when every domain is out of reset and no soft reset is in progress.
- lock_lost  out  1  sticky flag: lock dropped after sequencing began.
- lock_lost_clr  in  1  one-cycle clear for lock_lost.

## Operation
- pll_lock passes through a 2-FF synchronizer, giving lock_s.
- FSM states: WAIT_LOCK, RELEASE, RUN, SOFT, ACK.
- WAIT_LOCK:
  - dom_rst is all ones.
  - Filter counter increments while lock_s=1 and clears to 0 when lock_s=0.
  - When the counter reaches LOCK_FILT, go to RELEASE with step=0 and cnt=0.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==REL_DELAY-1: clear dom_rst[step], set cnt=0, increment step.
  - After domain N_DOM-1 is released, go to RUN.
- RUN:
  - all_ready=1.
  - If sw_rst_req≠0: latch mask=sw_rst_req, set dom_rst|=mask, clear cnt, go to SOFT.
- SOFT:
  - After SOFT_LEN cycles, clear dom_rst bits in mask, then go to ACK.
- ACK:
  - sw_rst_ack=1.
  - When sw_rst_req==0, go to RUN.
  - A new nonzero request is served only after req has been seen at 0 for one cycle (4-phase handshake).
- Lock loss: lock_s=0 in RELEASE, RUN, SOFT or ACK causes all of the following on the next edge:
  - dom_rst set to all ones, all_ready=0, sw_rst_ack=0;
  - lock_lost set to 1;
  - state goes to WAIT_LOCK, filter counter cleared.
- Priority: lock loss beats soft request, beats ack completion. When set and clear of lock_lost land in the same cycle, set wins.
- Requests present outside RUN are ignored. A request still held when RUN is re-entered is served normally.
- Requests targeting already-resetting bits are not possible, because requests are sampled only in RUN.

## Timing
- All outputs are registered.
- Reset values (rst_n=0): dom_rst all ones, all_ready=0, sw_rst_ack=0, lock_lost=0, state WAIT_LOCK, all counters 0.
- Lock latency:
  - pll_lock rise to lock_s: 2 cycles.
  - Filter adds LOCK_FILT cycles.
  - Domain 0 releases REL_DELAY cycles after entering RELEASE.
  - Domain i releases (i+1)·REL_DELAY cycles after entering RELEASE.
- all_ready rises 1 cycle after the last release.
- Soft reset:
  - Masked dom_rst bits rise and all_ready falls 1 cycle after the request is sampled.
  - Bits held SOFT_LEN cycles.
  - sw_rst_ack rises in the same cycle the bits fall.
  - sw_rst_ack falls 1 cycle after req is seen at 0.
- Lock loss: 2-cycle synchronizer delay, then 1 cycle to dom_rst all ones.
- Counter widths are $clog2(max(LOCK_FILT, REL_DELAY, SOFT_LEN)+1). The step counter is $clog2(N_DOM+1) bits. Counters never wrap, because they reset on terminal count.
- rst_n may assert mid-sequence at any time: asynchronous return to reset values, no glitch on dom_rst (stays high).

## Structure
- Shared header iua_rst_defs.vh holds:
  - state encodings (WAIT_LOCK=0, RELEASE=1, RUN=2, SOFT=3, ACK=4, 3 bits);
  - default parameter constants.
- Sub-module iua_sync2: generic 2-FF synchronizer with async active-low reset to 0. Instantiated for pll_lock and reusable elsewhere.

## Test plan
- Power-up, N_DOM=4, LOCK_FILT=8, REL_DELAY=16, pll_lock high from cycle 0 → dom_rst bits clear in order 0..3, 16 cycles apart, first release at cycle 2+8+16 ±1; all_ready=1 one cycle after bit 3 clears.
- Glitchy lock: pll_lock high 5 cycles, low 1, then high → filter restarts; no domain released before 8 consecutive high cycles.
- Soft reset: in RUN, sw_rst_req=4'b0101 → dom_rst=4'b0101 for 8 cycles; then ack=1; hold req 3 more cycles → ack stays 1; drop req → ack=0 next cycle, all_ready=1.
- Lock loss during RELEASE after domain 1 is released → dom_rst=4'b1111 3 cycles after pll_lock falls, lock_lost=1; relock re-sequences from domain 0; lock_lost_clr clears the flag.
- Lock loss during SOFT → ack never asserts; held req is served after the next full sequence.
- Async rst_n pulse mid-RELEASE → immediate reset values; full sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/iua_rst_ctrl_pkg.sv
// Shared constants for the reset sequencer: FSM state encodings, default
// parameters and a small sizing helper.
package iua_rst_ctrl_pkg;

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_RELEASE   = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_SOFT      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;

    localparam int unsigned DEF_N_DOM     = 4;
    localparam int unsigned DEF_LOCK_FILT = 8;
    localparam int unsigned DEF_REL_DELAY = 16;
    localparam int unsigned DEF_SOFT_LEN  = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/iua_sync2.sv
// Generic two-flop synchronizer, async active-low reset to zero.
module iua_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iua_rst_ctrl.sv
// Reset sequencer: filters PLL lock, releases domains one by one, serves
// per-domain soft resets over a 4-phase req/ack handshake.
module iua_rst_ctrl
    import iua_rst_ctrl_pkg::*;
#(
    parameter int unsigned N_DOM     = DEF_N_DOM,
    parameter int unsigned LOCK_FILT = DEF_LOCK_FILT,
    parameter int unsigned REL_DELAY = DEF_REL_DELAY,
    parameter int unsigned SOFT_LEN  = DEF_SOFT_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic [N_DOM-1:0] sw_rst_req,
    output logic             sw_rst_ack,
    output logic [N_DOM-1:0] dom_rst,
    output logic             all_ready,
    output logic             lock_lost,
    input  logic             lock_lost_clr
);

    localparam int unsigned CW = $clog2(max3(LOCK_FILT, REL_DELAY, SOFT_LEN) + 1);
    localparam int unsigned SW = $clog2(N_DOM + 1);

    logic             lock_s;
    logic [2:0]       state, state_nxt;
    logic [CW-1:0]    filt, filt_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [SW-1:0]    step, step_nxt;
    logic [N_DOM-1:0] mask, mask_nxt;
    logic [N_DOM-1:0] dom_rst_nxt;
    logic             ack_nxt, ready_nxt, lost_nxt;

    iua_sync2 #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT_LOCK;
            filt       <= '0;
            cnt        <= '0;
            step       <= '0;
            mask       <= '0;
            dom_rst    <= '1;
            sw_rst_ack <= 1'b0;
            all_ready  <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state      <= state_nxt;
            filt       <= filt_nxt;
            cnt        <= cnt_nxt;
            step       <= step_nxt;
            mask       <= mask_nxt;
            dom_rst    <= dom_rst_nxt;
            sw_rst_ack <= ack_nxt;
            all_ready  <= ready_nxt;
            lock_lost  <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        filt_nxt    = filt;
        cnt_nxt     = cnt;
        step_nxt    = step;
        mask_nxt    = mask;
        dom_rst_nxt = dom_rst;
        ack_nxt     = sw_rst_ack;
        lost_nxt    = lock_lost_clr ? 1'b0 : lock_lost;

        case (state)
            ST_WAIT_LOCK: begin
                dom_rst_nxt = '1;
                ack_nxt     = 1'b0;
                if (!lock_s) begin
                    filt_nxt = '0;
                end else if (filt == CW'(LOCK_FILT - 1)) begin
                    state_nxt = ST_RELEASE;
                    filt_nxt  = '0;
                    cnt_nxt   = '0;
                    step_nxt  = '0;
                end else begin
                    filt_nxt = filt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt == CW'(REL_DELAY - 1)) begin
                    cnt_nxt  = '0;
                    step_nxt = step + 1'b1;
                    for (int i = 0; i < int'(N_DOM); i++) begin
                        if (SW'(i) == step) dom_rst_nxt[i] = 1'b0;
                    end
                    if (step == SW'(N_DOM - 1)) state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_rst_req != '0) begin
                    mask_nxt    = sw_rst_req;
                    dom_rst_nxt = dom_rst | sw_rst_req;
                    cnt_nxt     = '0;
                    state_nxt   = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (cnt == CW'(SOFT_LEN - 1)) begin
                    dom_rst_nxt = dom_rst & ~mask;
                    ack_nxt     = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_ACK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ACK: begin
                if (sw_rst_req == '0) begin
                    ack_nxt   = 1'b0;
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                dom_rst_nxt = '1;
                state_nxt   = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss overrides everything, including a lock_lost clear
        if (state != ST_WAIT_LOCK && !lock_s) begin
            dom_rst_nxt = '1;
            ack_nxt     = 1'b0;
            lost_nxt    = 1'b1;
            state_nxt   = ST_WAIT_LOCK;
            filt_nxt    = '0;
            cnt_nxt     = '0;
            step_nxt    = '0;
        end

        // Ready only while settled in RUN: one cycle after release, same edge as ack drop
        ready_nxt = (state == ST_RUN || state == ST_ACK) && (state_nxt == ST_RUN);
    end

endmodule

// File: tb/tb_iua_rst_ctrl.sv
// Scoreboard bench for iua_rst_ctrl: expected output transitions are queued
// with their cycle, and a negedge monitor matches every observed change.
module tb_iua_rst_ctrl;

    localparam int unsigned N_DOM     = 4;
    localparam int unsigned LOCK_FILT = 8;
    localparam int unsigned REL_DELAY = 16;
    localparam int unsigned SOFT_LEN  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pll_lock;
    logic [N_DOM-1:0] sw_rst_req;
    logic             sw_rst_ack;
    logic [N_DOM-1:0] dom_rst;
    logic             all_ready;
    logic             lock_lost;
    logic             lock_lost_clr;

    iua_rst_ctrl #(
        .N_DOM     (N_DOM),
        .LOCK_FILT (LOCK_FILT),
        .REL_DELAY (REL_DELAY),
        .SOFT_LEN  (SOFT_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .sw_rst_ack    (sw_rst_ack),
        .dom_rst       (dom_rst),
        .all_ready     (all_ready),
        .lock_lost     (lock_lost),
        .lock_lost_clr (lock_lost_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic       mon_en = 1'b0;
    logic [6:0] prev_v;
    logic [6:0] cur_v;

    // {lock_lost, sw_rst_ack, all_ready, dom_rst[3:0]}
    assign cur_v = {lock_lost, sw_rst_ack, all_ready, dom_rst};

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && cur_v !== prev_v) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur_v, prev_v);
            end else begin
                e = sbq.pop_front();
                if (e.v !== cur_v || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL event got=%b at cyc %0d, required=%b at cyc %0d",
                             cur_v, cyc, e.v, e.cyc);
                end
            end
        end
        prev_v = cur_v;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    int p, t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;

    initial begin
        rst_n         = 1'b0;
        pll_lock      = 1'b0;
        sw_rst_req    = '0;
        lock_lost_clr = 1'b0;
        tick(3);

        check("rst_dom_rst", 7'(dom_rst), 7'h0F);
        check("rst_all_ready", 7'(all_ready), 7'h00);
        check("rst_ack", 7'(sw_rst_ack), 7'h00);
        check("rst_lock_lost", 7'(lock_lost), 7'h00);

        prev_v = cur_v;
        mon_en = 1'b1;

        // Power-up with a one-cycle lock glitch after 5 high cycles
        p        = cyc;
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        push(p + 32, 7'b000_1110);
        push(p + 48, 7'b000_1100);
        push(p + 64, 7'b000_1000);
        push(p + 80, 7'b000_0000);
        push(p + 81, 7'b001_0000);
        wait_until(p + 5);
        pll_lock = 1'b0;
        wait_until(p + 6);
        pll_lock = 1'b1;
        wait_until(p + 31);
        check("glitch_no_early_release", 7'(dom_rst), 7'h0F);
        wait_until(p + 33);
        check("first_release", 7'(dom_rst), 7'h0E);

        // Soft reset of domains 0 and 2, req held past ack
        t0 = p + 85;
        wait_until(t0);
        sw_rst_req = 4'b0101;
        push(t0 + 1, 7'b000_0101);
        push(t0 + 9, 7'b010_0000);
        wait_until(t0 + 12);
        check("ack_held", 7'(sw_rst_ack), 7'h01);
        sw_rst_req = 4'b0000;
        push(t0 + 13, 7'b001_0000);

        // Lock loss in RUN, relock, lock loss in RELEASE after domain 1
        t1 = t0 + 16;
        wait_until(t1);
        pll_lock = 1'b0;
        push(t1 + 3, 7'b100_1111);
        t2 = t1 + 5;
        wait_until(t2);
        pll_lock = 1'b1;
        push(t2 + 26, 7'b100_1110);
        push(t2 + 42, 7'b100_1100);
        t3 = t2 + 45;
        wait_until(t3);
        pll_lock = 1'b0;
        push(t3 + 3, 7'b100_1111);
        wait_until(t3 + 5);
        lock_lost_clr = 1'b1;
        push(t3 + 6, 7'b000_1111);
        wait_until(t3 + 6);
        lock_lost_clr = 1'b0;
        t4 = t3 + 8;
        wait_until(t4);
        pll_lock = 1'b1;
        push(t4 + 26, 7'b000_1110);
        push(t4 + 42, 7'b000_1100);
        push(t4 + 58, 7'b000_1000);
        push(t4 + 74, 7'b000_0000);
        push(t4 + 75, 7'b001_0000);

        // Lock loss during SOFT with a simultaneous clear; held req served later
        t5 = t4 + 80;
        wait_until(t5);
        sw_rst_req = 4'b0011;
        push(t5 + 1, 7'b000_0011);
        wait_until(t5 + 2);
        pll_lock = 1'b0;
        push(t5 + 5, 7'b100_1111);
        wait_until(t5 + 4);
        lock_lost_clr = 1'b1;
        wait_until(t5 + 5);
        lock_lost_clr = 1'b0;
        t6 = t5 + 8;
        wait_until(t6);
        pll_lock = 1'b1;
        push(t6 + 26, 7'b100_1110);
        push(t6 + 42, 7'b100_1100);
        push(t6 + 58, 7'b100_1000);
        push(t6 + 74, 7'b100_0000);
        push(t6 + 75, 7'b100_0011);
        push(t6 + 83, 7'b110_0000);
        wait_until(t6 + 85);
        sw_rst_req = 4'b0000;
        push(t6 + 86, 7'b101_0000);

        // Async rst_n pulse mid-RELEASE
        t7 = t6 + 88;
        wait_until(t7);
        pll_lock = 1'b0;
        push(t7 + 3, 7'b100_1111);
        t8 = t7 + 5;
        wait_until(t8);
        pll_lock = 1'b1;
        push(t8 + 26, 7'b100_1110);
        push(t8 + 42, 7'b100_1100);
        t9 = t8 + 50;
        wait_until(t9);
        rst_n = 1'b0;
        push(t9, 7'b000_1111);
        #1;
        check("async_rst_values", cur_v, 7'b000_1111);
        wait_until(t9 + 2);
        rst_n = 1'b1;
        push(t9 + 28, 7'b000_1110);
        push(t9 + 44, 7'b000_1100);
        push(t9 + 60, 7'b000_1000);
        push(t9 + 76, 7'b000_0000);
        push(t9 + 77, 7'b001_0000);
        wait_until(t9 + 82);

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL missing_events remaining=%0d required=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
